// File: rtl/brnch_cmp_seq.sv
// Iterative signed comparator producing cndM/brnch_typeM for the M stage.
// In: clk rst start flush a b brnch_typeE  Out: busy done cndM brnch_typeM
module brnch_cmp_seq #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      brnch_typeE,
  output logic            busy,
  output logic            done,
  output logic [1:0]      cndM,
  output logic [1:0]      brnch_typeM
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [1:0]      typ_q, typ_d;
  logic [1:0]      cnd_q, cnd_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Operands shift left once per equal chunk, so the
  // chunk under test always sits in the top CHUNK bits.
  logic [CHUNK-1:0] ca, cb;
  logic             first;
  logic             gt, lt;

  assign ca    = a_q[XLEN-1 -: CHUNK];
  assign cb    = b_q[XLEN-1 -: CHUNK];
  assign first = (idx_q == '0);

  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    if (first) begin
      gt = $signed(ca) > $signed(cb);
      lt = $signed(ca) < $signed(cb);
    end else begin
      gt = ca > cb;
      lt = ca < cb;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    typ_d   = typ_q;
    cnd_d   = cnd_q;
    idx_d   = idx_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_d     = a;
            b_d     = b;
            typ_d   = brnch_typeE;
            idx_d   = '0;
            state_d = CMP;
          end
        end
        CMP: begin
          if (gt) begin
            cnd_d   = 2'b10;
            state_d = DONE;
          end else if (lt) begin
            cnd_d   = 2'b00;
            state_d = DONE;
          end else if (idx_q == LAST) begin
            cnd_d   = 2'b11;
            state_d = DONE;
          end else begin
            a_d   = a_q << CHUNK;
            b_d   = b_q << CHUNK;
            idx_d = idx_q + 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            a_d     = a;
            b_d     = b;
            typ_d   = brnch_typeE;
            idx_d   = '0;
            state_d = CMP;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == CMP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      typ_q   <= 2'b00;
      cnd_q   <= 2'b00;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      typ_q   <= typ_d;
      cnd_q   <= cnd_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cndM        = cnd_q;
  assign brnch_typeM = typ_q;

endmodule

// File: tb/tb_brnch_cmp_seq.sv
// Directed bench for brnch_cmp_seq (CHUNK=8 and CHUNK=32 instances).
// Table vectors plus hand sequences for back-to-back, flush, reset.
module tb_brnch_cmp_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        st8 = 1'b0;
  logic        st32 = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  typ = 2'b00;

  logic        busy8, done8, busy32, done32;
  logic [1:0]  cnd8, tm8, cnd32, tm32;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  brnch_cmp_seq #(.XLEN(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst(rst), .start(st8), .flush(flush),
    .a(a), .b(b), .brnch_typeE(typ),
    .busy(busy8), .done(done8),
    .cndM(cnd8), .brnch_typeM(tm8)
  );

  brnch_cmp_seq #(.XLEN(32), .CHUNK(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(st32), .flush(flush),
    .a(a), .b(b), .brnch_typeE(typ),
    .busy(busy32), .done(done32),
    .cndM(cnd32), .brnch_typeM(tm32)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  typ;
    logic [1:0]  cnd;
    int          lat;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 1 of the new operation.
  task automatic go(input bit wide, input logic [31:0] va,
                    input logic [31:0] vb, input logic [1:0] vt_);
    a   = va;
    b   = vb;
    typ = vt_;
    if (wide) st32 = 1'b1;
    else      st8 = 1'b1;
    tick();
    st8  = 1'b0;
    st32 = 1'b0;
  endtask

  // Returns the cycle index at which done is seen, counting busy cycles.
  task automatic wait_done(input bit wide, output int lat, output int nb);
    lat = 1;
    nb  = 0;
    while (!(wide ? done32 : done8) && lat < 20) begin
      if (wide ? busy32 : busy8) nb++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, nb, np, dc;
    vt[0] = '{32'h12345678, 32'h12345678, 2'b00, 2'b11, 5};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 2'b10, 2'b00, 2};
    vt[2] = '{32'h00000100, 32'h000000FF, 2'b11, 2'b10, 4};
    vt[3] = '{32'h7FFFFFFF, 32'h80000000, 2'b01, 2'b10, 2};
    vt[4] = '{32'h80000000, 32'h7FFFFFFF, 2'b10, 2'b00, 2};
    vt[5] = '{32'h000000FF, 32'h00000080, 2'b11, 2'b10, 5};
    vt[6] = '{32'h00008000, 32'h00000000, 2'b01, 2'b10, 4};
    vt[7] = '{32'h80000000, 32'h80000001, 2'b10, 2'b00, 5};
    vt[8] = '{32'h12000000, 32'h12FF0000, 2'b00, 2'b00, 3};

    tick();
    tick();
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_cnd", int'(cnd8), 0);
    chk("rst_typ", int'(tm8), 0);
    rst = 1'b0;
    tick();

    foreach (vt[i]) begin
      go(1'b0, vt[i].a, vt[i].b, vt[i].typ);
      wait_done(1'b0, lat, nb);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_busy", i), nb, vt[i].lat - 1);
      chk($sformatf("v%0d_cnd", i), int'(cnd8), int'(vt[i].cnd));
      chk($sformatf("v%0d_typ", i), int'(tm8), int'(vt[i].typ));
      tick();
      chk($sformatf("v%0d_pulse", i), int'(done8), 0);
      chk($sformatf("v%0d_idle", i), int'(busy8), 0);
    end

    // Back-to-back: restart in the DONE cycle.
    go(1'b0, 32'h7FFFFFFF, 32'h80000000, 2'b10);
    wait_done(1'b0, lat, nb);
    chk("b2b_lat1", lat, 2);
    chk("b2b_cnd1", int'(cnd8), 2);
    go(1'b0, 32'h0, 32'h0, 2'b00);
    chk("b2b_nogap", int'(busy8), 1);
    wait_done(1'b0, lat, nb);
    chk("b2b_lat2", lat, 5);
    chk("b2b_cnd2", int'(cnd8), 3);
    tick();

    // Flush at cycle 2: would have produced 10 at cycle 5.
    go(1'b0, 32'h00000001, 32'h00000000, 2'b00);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", int'(busy8), 0);
    np = 0;
    for (int c = 0; c < 8; c++) begin
      if (done8) np++;
      tick();
    end
    chk("fl_nodone", np, 0);
    chk("fl_cnd", int'(cnd8), 3);

    // Start held through CMP: only one done, at cycle 5.
    a   = 32'h55AA55AA;
    b   = 32'h55AA55AA;
    typ = 2'b01;
    st8 = 1'b1;
    np  = 0;
    dc  = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 3) a = 32'h00000000;
      if (c == 5) st8 = 1'b0;
      if (done8) begin
        np++;
        dc = c;
      end
    end
    st8 = 1'b0;
    chk("hold_pulses", np, 1);
    chk("hold_cyc", dc, 5);
    chk("hold_cnd", int'(cnd8), 3);
    chk("hold_typ", int'(tm8), 1);

    // Reset at cycle 3 of a comparison.
    go(1'b0, 32'h0000ABCD, 32'h0000ABCD, 2'b11);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mr_busy", int'(busy8), 0);
    chk("mr_done", int'(done8), 0);
    chk("mr_cnd", int'(cnd8), 0);
    chk("mr_typ", int'(tm8), 0);
    rst = 1'b0;
    tick();

    // Single-cycle compare with CHUNK=32.
    foreach (vt[i]) begin
      go(1'b1, vt[i].a, vt[i].b, vt[i].typ);
      wait_done(1'b1, lat, nb);
      chk($sformatf("w%0d_lat", i), lat, 2);
      chk($sformatf("w%0d_cnd", i), int'(cnd32), int'(vt[i].cnd));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
